eth_rx_frame_filter: RTL

Receive-side frame qualifier that sits directly downstream of the RMII byte assembler/preamble stripper in the clk50 domain. It consumes the SFD-stripped byte stream (sof/vld/byte/eof), filters on destination MAC, checks the Ethernet FCS (CRC-32), strips the 4 FCS bytes and forwards the frame bytes. It issues a one-cycle status word per frame and keeps good/dropped frame counters for the downstream packet parser and debug UART.

---
 rtl/eth_rx_frame_filter.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/eth_rx_frame_filter.sv
// eth_rx_frame_filter
//
// Receive-side frame qualifier in the clk50 domain. Takes the SFD-stripped
// byte stream from the RMII assembler, filters on destination MAC, checks
// the Ethernet FCS (reflected CRC-32 residue), strips the 4 FCS bytes and
// forwards the rest. One status strobe per frame plus good/drop counters.
//
// Ports
//   clk50, rst        : 50 MHz clock, asynchronous active-high reset
//   in_sof/in_vld     : byte strobe (sof marks byte 0), at most one per 4 cycles
//   in_byte           : received byte
//   in_eof            : end-of-frame pulse, never together with in_vld
//   out_sof/out_vld   : forwarded byte strobe (sof marks first forwarded byte)
//   out_byte          : forwarded byte
//   out_eof           : pulse after the last forwarded byte of a started frame
//   stat_vld          : one-cycle status strobe carrying the stat_* fields
//   stat_ok/_crc_err/_len_err/_addr_miss, stat_len : per-frame status
//   cnt_ok, cnt_drop  : wrapping frame counters, updated the cycle after stat_vld
//   dbg_state         : current FSM state (IDLE=0 FILL=1 STREAM=2 FLUSH=3 DONE=4)
//
// Stream semantics: valid-only, no backpressure. A byte is transferred in
// every cycle its *_vld is high; consumers must accept it in that cycle.

module eth_rx_frame_filter #(
  parameter logic [47:0] MAC_ADDR     = 48'h02_00_00_00_00_01,
  parameter bit          ACCEPT_BCAST = 1'b1,
  parameter int          MIN_LEN      = 64,
  parameter int          MAX_LEN      = 1518
) (
  input  logic        clk50,
  input  logic        rst,
  input  logic        in_sof,
  input  logic        in_vld,
  input  logic [7:0]  in_byte,
  input  logic        in_eof,
  output logic        out_sof,
  output logic        out_vld,
  output logic [7:0]  out_byte,
  output logic        out_eof,
  output logic        stat_vld,
  output logic        stat_ok,
  output logic        stat_crc_err,
  output logic        stat_len_err,
  output logic        stat_addr_miss,
  output logic [10:0] stat_len,
  output logic [15:0] cnt_ok,
  output logic [15:0] cnt_drop,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL   = 3'd1,
    STREAM = 3'd2,
    FLUSH  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [10:0] MIN_L       = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L       = 11'(MAX_LEN);

  state_t          state;
  logic [5:0][7:0] dl;         // dl[0] newest, dl[5] oldest
  logic [31:0]     crc;
  logic [10:0]     len;        // bytes received so far, saturating
  logic            uc_match;   // destination bytes so far equal MAC_ADDR
  logic            bc_match;   // destination bytes so far all 0xFF
  logic            hit;        // destination accepted (valid once byte 5 seen)
  logic            started;    // out_sof already issued for this frame
  logic            flush_cnt;

  // Reflected CRC-32 over one byte, LSB first, no final inversion.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ CRC_POLY;
      else             r = r >> 1;
    end
    return r;
  endfunction

  logic [31:0] crc_nxt;
  logic [31:0] crc_first;
  logic [10:0] len_inc;
  logic [7:0]  mac_sel;
  logic        byte_uc;
  logic        byte0_uc;
  logic        byte_bc;
  logic        crc_bad;
  logic        len_bad;
  logic        hit_now;

  assign crc_nxt   = crc_byte(crc, in_byte);
  assign crc_first = crc_byte(CRC_INIT, in_byte);
  assign len_inc   = (len == 11'h7FF) ? len : len + 11'd1;
  assign byte_uc   = (in_byte == mac_sel);
  assign byte0_uc  = (in_byte == MAC_ADDR[47:40]);
  assign byte_bc   = (in_byte == 8'hFF);
  assign crc_bad   = (crc != CRC_RESIDUE);
  assign len_bad   = (len < MIN_L) || (len > MAX_L);
  // Address decision as byte 5 arrives: previous five matches plus this byte.
  assign hit_now   = (uc_match && byte_uc) || (ACCEPT_BCAST && bc_match && byte_bc);
  assign dbg_state = state;

  // MAC byte expected at wire position len (byte 0 = MAC_ADDR[47:40]).
  always_comb begin
    mac_sel = MAC_ADDR[47:40];
    case (len[2:0])
      3'd1:    mac_sel = MAC_ADDR[39:32];
      3'd2:    mac_sel = MAC_ADDR[31:24];
      3'd3:    mac_sel = MAC_ADDR[23:16];
      3'd4:    mac_sel = MAC_ADDR[15:8];
      3'd5:    mac_sel = MAC_ADDR[7:0];
      default: mac_sel = MAC_ADDR[47:40];
    endcase
  end

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      dl             <= '0;
      crc            <= CRC_INIT;
      len            <= '0;
      uc_match       <= 1'b0;
      bc_match       <= 1'b0;
      hit            <= 1'b0;
      started        <= 1'b0;
      flush_cnt      <= 1'b0;
      out_sof        <= 1'b0;
      out_vld        <= 1'b0;
      out_byte       <= '0;
      out_eof        <= 1'b0;
      stat_vld       <= 1'b0;
      stat_ok        <= 1'b0;
      stat_crc_err   <= 1'b0;
      stat_len_err   <= 1'b0;
      stat_addr_miss <= 1'b0;
      stat_len       <= '0;
      cnt_ok         <= '0;
      cnt_drop       <= '0;
    end else begin
      out_sof        <= 1'b0;
      out_vld        <= 1'b0;
      out_eof        <= 1'b0;
      stat_vld       <= 1'b0;
      stat_ok        <= 1'b0;
      stat_crc_err   <= 1'b0;
      stat_len_err   <= 1'b0;
      stat_addr_miss <= 1'b0;
      stat_len       <= '0;

      if (stat_vld) begin
        if (stat_ok) cnt_ok   <= cnt_ok + 16'd1;
        else         cnt_drop <= cnt_drop + 16'd1;
      end

      if (in_vld && in_sof && (state == IDLE || state == FILL || state == STREAM)) begin
        // A new sof inside an open frame aborts it: report it now, drop the
        // bytes still in the delay line, and restart on the new byte.
        if (state != IDLE) begin
          out_eof        <= started;
          stat_vld       <= 1'b1;
          stat_crc_err   <= crc_bad;
          stat_len_err   <= 1'b1;
          stat_addr_miss <= !hit;
          stat_len       <= len;
        end
        crc      <= crc_first;
        len      <= 11'd1;
        dl       <= {40'd0, in_byte};
        uc_match <= byte0_uc;
        bc_match <= byte_bc;
        hit      <= 1'b0;
        started  <= 1'b0;
        state    <= FILL;
      end else begin
        case (state)
          FILL: begin
            if (in_vld) begin
              dl       <= {dl[4:0], in_byte};
              crc      <= crc_nxt;
              len      <= len_inc;
              uc_match <= uc_match && byte_uc;
              bc_match <= bc_match && byte_bc;
              if (len == 11'd5) begin
                hit   <= hit_now;
                state <= STREAM;
              end
            end else if (in_eof) begin
              // Runt: destination never completed, report immediately.
              stat_vld       <= 1'b1;
              stat_crc_err   <= crc_bad;
              stat_len_err   <= 1'b1;
              stat_addr_miss <= 1'b1;
              stat_len       <= len;
              state          <= DONE;
            end
          end

          STREAM: begin
            if (in_vld) begin
              dl  <= {dl[4:0], in_byte};
              crc <= crc_nxt;
              len <= len_inc;
              if (hit) begin
                out_vld  <= 1'b1;
                out_byte <= dl[5];
                out_sof  <= !started;
                started  <= 1'b1;
              end
            end else if (in_eof) begin
              // dl[5], dl[4] are the last payload bytes; dl[3:0] is the FCS.
              if (hit) begin
                out_vld  <= 1'b1;
                out_byte <= dl[5];
                out_sof  <= !started;
                started  <= 1'b1;
              end
              flush_cnt <= 1'b0;
              state     <= FLUSH;
            end
          end

          FLUSH: begin
            if (!flush_cnt) begin
              if (hit) begin
                out_vld  <= 1'b1;
                out_byte <= dl[4];
                out_sof  <= !started;
                started  <= 1'b1;
              end
              flush_cnt <= 1'b1;
            end else begin
              out_eof        <= started;
              stat_vld       <= 1'b1;
              stat_ok        <= hit && !crc_bad && !len_bad;
              stat_crc_err   <= crc_bad;
              stat_len_err   <= len_bad;
              stat_addr_miss <= !hit;
              stat_len       <= len;
              state          <= DONE;
            end
          end

          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
